load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 32 +++
 rtl/load_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size and FSM state encodings shared by the load/store unit and its lane aligner.
package lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ACCESS    = 2'b01,
      WRITEBACK = 2'b10,
      RESP      = 2'b11
   } state_e;

   function automatic logic is_sub(input logic [1:0] size);
      return size == SIZE_BYTE || size == SIZE_HALF;
   endfunction

   // Size 2'b11 is a word, so anything that is not byte/half must be word aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == SIZE_HALF && off[0]) || (!is_sub(size) && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: big-endian lane extract/extend for loads and read-modify-write merge for sub-word stores.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int width = 32
) (
   input  logic [1:0]       size,
   input  logic             sgn,
   input  logic [1:0]       off,
   input  logic [width-1:0] rword,
   input  logic [width-1:0] wdata,
   output logic [width-1:0] ldata,
   output logic [width-1:0] mdata
);

   logic [4:0]       sh;
   logic [7:0]       byte_l;
   logic [15:0]      half_l;
   logic [width-1:0] mask;

   // Offset 0 is the most significant lane, so the shift counts down from the top.
   always_comb begin
      sh     = size == SIZE_BYTE ? {~off, 3'b000} : {~off[1], 4'b0000};
      byte_l = 8'(rword >> sh);
      half_l = 16'(rword >> sh);
      ldata  = size == SIZE_BYTE ? {{(width-8){sgn & byte_l[7]}}, byte_l} :
               size == SIZE_HALF ? {{(width-16){sgn & half_l[15]}}, half_l} : rword;
      mask   = (size == SIZE_BYTE ? width'(8'hFF) : width'(16'hFFFF)) << sh;
      mdata  = (rword & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store engine onto a word-organised data memory.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned half/word requests with resp_error instead of ignoring low bits.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int addresswidth = 32,
   parameter int width        = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [addresswidth-1:0] req_addr,
   input  logic [width-1:0]        req_wdata,
   output logic                    resp_valid,
   output logic [width-1:0]        resp_rdata,
   output logic                    resp_error,
   output logic [addresswidth-1:0] dataMemoryAddress,
   output logic                    dataMemorywriteEnable,
   output logic [width-1:0]        dataMemorydataIn,
   input  logic [width-1:0]        dataMemorydataOut
);

   state_e                  state_q, state_d;
   logic                    write_q, write_d, signed_q, signed_d;
   logic                    we_q, we_d, valid_q, valid_d, err_q, err_d;
   logic [1:0]              size_q, size_d, off_q, off_d;
   logic [addresswidth-1:0] addr_q, addr_d;
   logic [width-1:0]        din_q, din_d, rdata_q, rdata_d;
   logic [width-1:0]        ldata, mdata;
   logic                    accept, mis;

   lsu_align #(.width(width)) u_align (
      .size  (size_q),
      .sgn   (signed_q),
      .off   (off_q),
      .rword (dataMemorydataOut),
      .wdata (din_q),
      .ldata (ldata),
      .mdata (mdata)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis        = misaligned(req_size, req_addr[1:0]);
   assign resp_error = err_q;
`else
   assign mis        = 1'b0;
   assign resp_error = 1'b0;
`endif

   assign req_ready             = state_q == IDLE && !reset;
   assign accept                = req_valid && req_ready;
   assign resp_valid            = valid_q;
   assign resp_rdata            = rdata_q;
   assign dataMemoryAddress     = addr_q;
   assign dataMemorydataIn      = din_q;
   assign dataMemorywriteEnable = we_q && !reset;

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      signed_d = signed_q;
      size_d   = size_q;
      off_d    = off_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rdata_d  = rdata_q;
      we_d     = 1'b0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            write_d  = req_write;
            signed_d = req_signed;
            size_d   = req_size;
            off_d    = req_addr[1:0];
            addr_d   = {req_addr[addresswidth-1:2], 2'b00};
            din_d    = req_wdata;
            state_d  = mis ? RESP : ACCESS;
            valid_d  = mis;
            err_d    = mis;
            rdata_d  = mis ? '0 : rdata_q;
            we_d     = !mis && req_write && !is_sub(req_size);
         end
         ACCESS: if (write_q && is_sub(size_q)) begin
            state_d = WRITEBACK;
            we_d    = 1'b1;
            din_d   = mdata;
         end else begin
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = write_q ? rdata_q : ldata;
         end
         WRITEBACK: begin
            state_d = RESP;
            valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         off_q    <= 2'b00;
         addr_q   <= '0;
         din_q    <= '0;
         rdata_q  <= '0;
         we_q     <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         size_q   <= size_d;
         off_q    <= off_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rdata_q  <= rdata_d;
         we_q     <= we_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

endmodule
